data_memory_ctrl: RTL and testbench

Parametrised single-port data memory with a request/response handshake, byte-lane write strobes, synchronous one-cycle read latency and a hardware clear sequence after reset. It replaces the fixed 8-bit × 256 data memory in the datapath's memory stage. It is generalised in word width and depth. Reset no longer clears the whole array in one step: a counter-driven CLEAR state walks the array one word per cycle, and the block refuses requests until the clear is complete.

---
 rtl/data_memory_ctrl.sv | 100 ++++++++++
 tb/tb_data_memory_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Single-port data memory with request/response handshake, byte-lane strobes,
// one-cycle read latency and a word-per-cycle clear sequence after reset.
module data_memory_ctrl #(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 8,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic              clr_we;
  logic              accept, wr_en, rd_en;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + (ADDR_W + 1)'(1);
        if (clr_cnt_q == CLR_LAST) state_d = ST_RUN;
      end
      ST_RUN: state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase
  end

  assign req_ready = (state_q == ST_RUN);
  assign init_done = (state_q == ST_RUN);
  assign accept    = req_valid && req_ready;
  assign wr_en     = accept && req_write;
  assign rd_en     = accept && !req_write;

  // NOTE: the array is deliberately not reset; the CLEAR walk zeroes it one
  // word per cycle, which keeps it mappable to plain storage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[clr_cnt_q[ADDR_W-1:0]] <= '0;
      end else if (wr_en) begin
        for (int i = 0; i < BE_W; i++) begin
          if (req_be[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read data is held between reads; reset drops any in-flight response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rd_en;
      if (rd_en) rsp_rdata_q <= mem[req_addr];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl (16-bit words, 256 deep) against a
// cycle-level behavioural model of the memory and its clear period.
module tb_data_memory_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int BE_W   = DATA_W / 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              init_done;

  data_memory_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: cycles spent clearing since reset, memory contents, response regs.
  int                clr_cycles = 0;
  bit                started    = 1'b0;
  bit                m_rsp_v    = 1'b0;
  logic [DATA_W-1:0] m_rsp_d    = '0;
  logic [DATA_W-1:0] m_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: model consumes pre-edge inputs, outputs are compared #1 later.
  task automatic step();
    bit                rst_s, vld_s, wr_s, ready_s;
    logic [ADDR_W-1:0] a_s;
    logic [DATA_W-1:0] d_s;
    logic [BE_W-1:0]   be_s;
    rst_s = rst; vld_s = req_valid; wr_s = req_write;
    a_s = req_addr; d_s = req_wdata; be_s = req_be;
    ready_s = (clr_cycles >= DEPTH);
    @(posedge clk);
    if (rst_s) begin
      started    = 1'b1;
      clr_cycles = 0;
      m_rsp_v    = 1'b0;
      m_rsp_d    = '0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else if (!ready_s) begin
      clr_cycles++;
      m_rsp_v = 1'b0;
    end else begin
      m_rsp_v = 1'b0;
      if (vld_s && wr_s) begin
        for (int i = 0; i < BE_W; i++)
          if (be_s[i]) m_mem[a_s][8*i +: 8] = d_s[8*i +: 8];
      end else if (vld_s) begin
        m_rsp_v = 1'b1;
        m_rsp_d = m_mem[a_s];
      end
    end
    #1;
    if (started) begin
      check("model_ready", 32'(req_ready), 32'(clr_cycles >= DEPTH));
      check("model_init_done", 32'(init_done), 32'(clr_cycles >= DEPTH));
      check("model_rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
      check("model_rsp_rdata", 32'(rsp_rdata), 32'(m_rsp_d));
    end
  endtask

  task automatic idle();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_be = be;
    step();
    idle();
  endtask

  // Leaves the response of the accepted read visible on the outputs.
  task automatic rd(input logic [ADDR_W-1:0] a);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    req_wdata = 16'(($urandom)); req_be = 2'($urandom);
    step();
    idle();
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (!req_ready && n < 1000) begin
      step();
      n++;
    end
    check(tag, 32'(n), 32'(DEPTH));
    check({tag, "_init_done"}, 32'(init_done), 32'd1);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step(); step();
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    wait_clear("clear_len");

    rd(0);   check("clr_rd0", 32'(rsp_rdata), 32'h0);
    rd(100); check("clr_rd100", 32'(rsp_rdata), 32'h0);
    rd(255); check("clr_rd255", 32'(rsp_rdata), 32'h0);

    wr(5, 16'hBEEF, 2'b11);
    rd(5);
    check("beef_valid", 32'(rsp_valid), 32'd1);
    check("beef_data", 32'(rsp_rdata), 32'hBEEF);
    step();
    check("beef_pulse_end", 32'(rsp_valid), 32'd0);

    wr(3, 16'h1234, 2'b11);
    wr(3, 16'hABCD, 2'b01);
    rd(3); check("lane_merge", 32'(rsp_rdata), 32'h12CD);
    wr(3, 16'h5A5A, 2'b00);
    rd(3); check("lane_noop", 32'(rsp_rdata), 32'h12CD);

    wr(1, 16'h1111, 2'b11);
    wr(2, 16'h2222, 2'b11);
    req_valid = 1'b1; req_write = 1'b0;
    for (int a = 1; a <= 3; a++) begin
      req_addr = ADDR_W'(a);
      step();
      check("b2b_valid", 32'(rsp_valid), 32'd1);
    end
    check("b2b_last", 32'(rsp_rdata), 32'h12CD);
    idle();
    step();
    check("b2b_hold_valid", 32'(rsp_valid), 32'd0);
    check("b2b_hold_data", 32'(rsp_rdata), 32'h12CD);

    for (int c = 0; c < 600; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = $urandom_range(0, 1) == 1;
      req_addr  = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
      req_wdata = DATA_W'($urandom);
      req_be    = BE_W'($urandom);
      step();
    end
    idle();

    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 0; req_wdata = 16'h00FF; req_be = 2'b11;
    wait_clear("clear_held_req");
    step();
    idle();
    rd(0); check("held_write", 32'(rsp_rdata), 32'h00FF);

    wr(7, 16'h0055, 2'b11);
    rd(7); check("pre_rst_rd7", 32'(rsp_rdata), 32'h0055);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7; rst = 1'b1;
    step();
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    check("midrst_data", 32'(rsp_rdata), 32'd0);
    idle(); rst = 1'b0;
    wait_clear("clear_restart");
    rd(7); check("post_rst_rd7", 32'(rsp_rdata), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
